// File: rtl/gaussian_c1_wr_arbiter.sv
// Round-robin arbiter sharing the CCI-P c1 write channel among NUM_REQ requesters,
// with burst locking, mdata requester tagging, line credits and response routing.
package gaussian_c1_wr_arbiter_pkg;
    localparam logic [3:0] eREQ_WRLINE_I = 4'h0;
    localparam logic [3:0] eREQ_WRLINE_M = 4'h1;
    localparam logic [3:0] eREQ_WRFENCE  = 4'h4;
    localparam logic [3:0] eRSP_WRLINE   = 4'h1;
    localparam logic [3:0] eRSP_WRFENCE  = 4'h4;

    typedef struct packed {
        logic [1:0]  vc_sel;
        logic        sop;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        hit_miss;
        logic        format;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;
endpackage

module gaussian_c1_wr_arbiter
    import gaussian_c1_wr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned TAG_LSB         = 13,
    parameter int unsigned MAX_OUTSTANDING = 64
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  t_ccip_c1_ReqMemHdr [NUM_REQ-1:0]       req_hdr,
    input  logic [NUM_REQ-1:0][511:0]              req_data,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic                                   c1TxAlmFull,
    output t_if_ccip_c1_Tx                         ccip_c1_tx,
    input  t_if_ccip_c1_Rx                         ccip_c1_rx,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    output logic [2:0]                             rsp_lines,
    output logic [NUM_REQ-1:0][6:0]                outstanding,
    output logic                                   err
);
    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Tag field is wide enough for an 8-requester build so out-of-range tags are detectable
    localparam int unsigned TAG_W = (TAG_LSB + 3 <= 16) ? 3 : ID_W;
    localparam int unsigned CNT_W = 7;

    typedef enum logic {IDLE, LOCKED} stateT;

    stateT              state, nextState;
    logic [ID_W-1:0]    rrPtr, owner, grantIdx, selIdx;
    logic [1:0]         beatsLeft;
    logic               grantFound;
    int                 scanDist, bestDist;
    logic [NUM_REQ-1:0] eligible, accept;
    logic               acceptAny;
    t_ccip_c1_ReqMemHdr selHdr, txHdr;
    logic [511:0]       selData;
    logic               tagDirty;

    logic [TAG_W-1:0]   rspTag;
    logic [2:0]         rspLinesC;
    logic               rspHit, rspBad;
    logic [NUM_REQ-1:0] rspPulse;
    logic [8:0]         credBase, credDec;
    logic [NUM_REQ-1:0][CNT_W-1:0] nextOut;
    logic               underflow, errSet;
    logic               unusedRx;

    assign unusedRx = ^ccip_c1_rx;

    // Credit-qualified sop requests and round-robin pick starting at rrPtr
    always_comb begin
        eligible   = '0;
        grantFound = 1'b0;
        grantIdx   = '0;
        bestDist   = int'(NUM_REQ);
        scanDist   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] & req_hdr[i].sop &
                          ((8'(outstanding[i]) + 8'(req_hdr[i].cl_len) + 8'd1) <= 8'(MAX_OUTSTANDING));
            scanDist = (i >= int'(rrPtr)) ? (i - int'(rrPtr)) : (i + int'(NUM_REQ) - int'(rrPtr));
            if (eligible[i] && (scanDist < bestDist)) begin
                bestDist   = scanDist;
                grantIdx   = ID_W'(i);
                grantFound = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (acceptAny && (selHdr.cl_len != 2'd0)) nextState = LOCKED;
            LOCKED:  if (acceptAny && (beatsLeft == 2'd1))     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Ready is combinational so almost-full stalls the very cycle it rises
    always_comb begin
        req_ready = '0;
        if (!reset && !c1TxAlmFull) begin
            if (state == LOCKED)  req_ready[owner]    = 1'b1;
            else if (grantFound)  req_ready[grantIdx] = 1'b1;
        end
    end

    assign accept    = req_valid & req_ready;
    assign acceptAny = |accept;
    assign selIdx    = (state == LOCKED) ? owner : grantIdx;
    assign selHdr    = req_hdr[selIdx];
    assign selData   = req_data[selIdx];
    assign tagDirty  = selHdr.mdata[TAG_LSB +: TAG_W] != '0;

    always_comb begin
        txHdr = selHdr;
        txHdr.mdata[TAG_LSB +: TAG_W] = TAG_W'(selIdx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rrPtr     <= '0;
            owner     <= '0;
            beatsLeft <= '0;
        end else if (acceptAny) begin
            if (state == IDLE) begin
                rrPtr     <= (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + ID_W'(1);
                owner     <= grantIdx;
                beatsLeft <= selHdr.cl_len;
            end else begin
                beatsLeft <= beatsLeft - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ccip_c1_tx <= '0;
        end else begin
            ccip_c1_tx.valid <= acceptAny;
            if (acceptAny) begin
                ccip_c1_tx.hdr  <= txHdr;
                ccip_c1_tx.data <= selData;
            end
        end
    end

    // Response decode: fences and unpacked responses retire one line
    always_comb begin
        rspTag    = ccip_c1_rx.hdr.mdata[TAG_LSB +: TAG_W];
        rspLinesC = ((ccip_c1_rx.hdr.resp_type == eRSP_WRFENCE) || !ccip_c1_rx.hdr.format)
                    ? 3'd1 : 3'(ccip_c1_rx.hdr.cl_num) + 3'd1;
        rspHit    = ccip_c1_rx.rspValid && (32'(rspTag) < NUM_REQ);
        rspBad    = ccip_c1_rx.rspValid && !rspHit;
        rspPulse  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rspPulse[i] = rspHit && (rspTag == TAG_W'(i));
        end
    end

    always_comb begin
        nextOut   = outstanding;
        underflow = 1'b0;
        credBase  = '0;
        credDec   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            credBase = 9'(outstanding[i]) + 9'(accept[i]);
            credDec  = rspPulse[i] ? 9'(rspLinesC) : 9'd0;
            if (credDec > credBase) begin
                nextOut[i] = '0;
                underflow  = 1'b1;
            end else begin
                nextOut[i] = CNT_W'(credBase - credDec);
            end
        end
    end

    assign errSet = (acceptAny && (state == LOCKED) && selHdr.sop) ||
                    (acceptAny && tagDirty) || rspBad || underflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            rsp_valid   <= '0;
            rsp_lines   <= '0;
            err         <= 1'b0;
        end else begin
            outstanding <= nextOut;
            rsp_valid   <= rspPulse;
            rsp_lines   <= rspHit ? rspLinesC : 3'd0;
            err         <= err | errSet;
        end
    end
endmodule
